// File: rtl/cp0_timer_irq.sv
// CP0 interrupt source: Count/Compare timer with prescaler, plus a two-flop
// synchronizer for the external IRQ lines, merged into the CAUSE IP[15:8] vector.
module cp0_timer_irq #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  irq_in,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] countreg,
    output logic [31:0] comparereg,
    output logic        timer_pending,
    output logic [7:0]  interrupts
);

    localparam int            PW      = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(COUNT_DIV - 1);
    localparam logic [PW-1:0] PS_ONE  = PW'(1);

    logic [PW-1:0] prescaler;
    logic [6:0]    irq_s1;
    logic [6:0]    irq_s2;
    logic          tick;
    logic          count_wr;
    logic          compare_wr;
    logic          match;

    assign tick       = (prescaler == PS_LAST);
    assign count_wr   = cp0_we && (cp0_waddr == 5'd9);
    assign compare_wr = cp0_we && (cp0_waddr == 5'd11);
    // Match looks one step ahead so pending rises together with Count reaching Compare.
    assign match      = tick && !count_wr && ((countreg + 32'd1) == comparereg);

    assign interrupts = {timer_pending, irq_s2};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            countreg      <= 32'd0;
            comparereg    <= 32'hFFFF_FFFF;
            timer_pending <= 1'b0;
            prescaler     <= '0;
            irq_s1        <= 7'd0;
            irq_s2        <= 7'd0;
        end else begin
            irq_s1 <= irq_in;
            irq_s2 <= irq_s1;

            // A Count write restarts the prescaler and swallows any tick this cycle.
            if (count_wr) begin
                countreg  <= cp0_wdata;
                prescaler <= '0;
            end else begin
                prescaler <= tick ? '0 : (prescaler + PS_ONE);
                if (tick)
                    countreg <= countreg + 32'd1;
            end

            // Compare write clears pending even if a match happens in the same cycle.
            if (compare_wr) begin
                comparereg    <= cp0_wdata;
                timer_pending <= 1'b0;
            end else if (match) begin
                timer_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cp0_timer_irq.sv
// Directed bench for cp0_timer_irq with COUNT_DIV=2: a per-cycle vector table
// followed by hand-written multi-cycle corner-case sequences.
module tb_cp0_timer_irq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  irq_in;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [31:0] countreg;
    logic [31:0] comparereg;
    logic        timer_pending;
    logic [7:0]  interrupts;

    int n_pass = 0;
    int n_total = 0;

    cp0_timer_irq #(.COUNT_DIV(2)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .irq_in        (irq_in),
        .cp0_we        (cp0_we),
        .cp0_waddr     (cp0_waddr),
        .cp0_wdata     (cp0_wdata),
        .countreg      (countreg),
        .comparereg    (comparereg),
        .timer_pending (timer_pending),
        .interrupts    (interrupts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [6:0]  irq;
        logic [31:0] cnt;
        logic [31:0] cmp;
        logic [7:0]  intr;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] addr, input logic [31:0] data);
        cp0_we    = we;
        cp0_waddr = addr;
        cp0_wdata = data;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 5'd0,  32'd0,   7'h00, 32'd0,   32'hFFFF_FFFF, 8'h00};
        tbl[1]  = '{1'b0, 5'd0,  32'd0,   7'h00, 32'd1,   32'hFFFF_FFFF, 8'h00};
        tbl[2]  = '{1'b0, 5'd0,  32'd0,   7'h08, 32'd1,   32'hFFFF_FFFF, 8'h00};
        tbl[3]  = '{1'b0, 5'd0,  32'd0,   7'h08, 32'd2,   32'hFFFF_FFFF, 8'h08};
        tbl[4]  = '{1'b0, 5'd0,  32'd0,   7'h00, 32'd2,   32'hFFFF_FFFF, 8'h08};
        tbl[5]  = '{1'b0, 5'd0,  32'd0,   7'h00, 32'd3,   32'hFFFF_FFFF, 8'h00};
        tbl[6]  = '{1'b0, 5'd0,  32'd0,   7'h08, 32'd3,   32'hFFFF_FFFF, 8'h00};
        tbl[7]  = '{1'b0, 5'd0,  32'd0,   7'h00, 32'd4,   32'hFFFF_FFFF, 8'h08};
        tbl[8]  = '{1'b0, 5'd0,  32'd0,   7'h00, 32'd4,   32'hFFFF_FFFF, 8'h00};
        tbl[9]  = '{1'b0, 5'd0,  32'd0,   7'h00, 32'd5,   32'hFFFF_FFFF, 8'h00};
        tbl[10] = '{1'b1, 5'd9,  32'd100, 7'h00, 32'd100, 32'hFFFF_FFFF, 8'h00};
        tbl[11] = '{1'b1, 5'd11, 32'd103, 7'h00, 32'd100, 32'd103,       8'h00};
        tbl[12] = '{1'b1, 5'd12, 32'd0,   7'h00, 32'd101, 32'd103,       8'h00};
        tbl[13] = '{1'b0, 5'd0,  32'd0,   7'h00, 32'd101, 32'd103,       8'h00};
        tbl[14] = '{1'b0, 5'd0,  32'd0,   7'h00, 32'd102, 32'd103,       8'h00};
        tbl[15] = '{1'b0, 5'd0,  32'd0,   7'h00, 32'd102, 32'd103,       8'h00};
        tbl[16] = '{1'b0, 5'd0,  32'd0,   7'h00, 32'd103, 32'd103,       8'h80};

        reset_n = 1'b0;
        irq_in  = 7'h00;
        drive(1'b0, 5'd0, 32'd0);
        step();
        step();
        chk("reset_count",   countreg,   32'd0);
        chk("reset_compare", comparereg, 32'hFFFF_FFFF);
        chk("reset_intr",    {24'd0, interrupts}, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].we, tbl[i].addr, tbl[i].data);
            irq_in = tbl[i].irq;
            step();
            chk($sformatf("vec%0d_count", i),   countreg,   tbl[i].cnt);
            chk($sformatf("vec%0d_compare", i), comparereg, tbl[i].cmp);
            chk($sformatf("vec%0d_intr", i),    {24'd0, interrupts}, {24'd0, tbl[i].intr});
        end
        drive(1'b0, 5'd0, 32'd0);

        // Pending holds through count 110, then a Compare write clears it.
        for (int i = 1; i <= 14; i++) begin
            step();
            chk($sformatf("hold%0d_count", i), countreg, 32'd103 + 32'(i / 2));
            chk($sformatf("hold%0d_pending", i), {31'd0, timer_pending}, 32'd1);
        end
        drive(1'b1, 5'd11, 32'd200);
        step();
        drive(1'b0, 5'd0, 32'd0);
        chk("clr_compare", comparereg, 32'd200);
        chk("clr_intr",    {24'd0, interrupts}, 32'h00);
        chk("clr_count",   countreg,   32'd110);

        // Wrap-around: FFFF_FFFE -> FFFF_FFFF -> 0 matches Compare=0.
        step();
        drive(1'b1, 5'd9, 32'hFFFF_FFFE);
        step();
        drive(1'b1, 5'd11, 32'd0);
        step();
        drive(1'b0, 5'd0, 32'd0);
        step();
        chk("wrap_ffff",        countreg, 32'hFFFF_FFFF);
        chk("wrap_ffff_pend",   {31'd0, timer_pending}, 32'd0);
        step();
        step();
        chk("wrap_zero",        countreg, 32'd0);
        chk("wrap_zero_pend",   {24'd0, interrupts}, 32'h80);

        // Compare write during a matching tick: clear wins, new value matches later.
        drive(1'b1, 5'd9, 32'd49);
        step();
        drive(1'b1, 5'd11, 32'd50);
        step();
        chk("sim_pre_pend", {31'd0, timer_pending}, 32'd0);
        drive(1'b1, 5'd11, 32'd60);
        step();
        drive(1'b0, 5'd0, 32'd0);
        chk("sim_count",   countreg,   32'd50);
        chk("sim_compare", comparereg, 32'd60);
        chk("sim_pend",    {31'd0, timer_pending}, 32'd0);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 19) chk("sim59_pend", {31'd0, timer_pending}, 32'd0);
        end
        chk("sim60_count", countreg, 32'd60);
        chk("sim60_pend",  {31'd0, timer_pending}, 32'd1);

        // Count write in a tick cycle: no increment, next one COUNT_DIV later.
        step();
        drive(1'b1, 5'd9, 32'd500);
        step();
        drive(1'b0, 5'd0, 32'd0);
        chk("cw_loaded", countreg, 32'd500);
        step();
        chk("cw_hold",   countreg, 32'd500);
        step();
        chk("cw_inc",    countreg, 32'd501);
        chk("cw_pend",   {31'd0, timer_pending}, 32'd1);

        // Count write equal to Compare must not set pending.
        drive(1'b1, 5'd11, 32'd1000);
        step();
        drive(1'b1, 5'd9, 32'd1000);
        step();
        drive(1'b0, 5'd0, 32'd0);
        chk("cweq_pend", {31'd0, timer_pending}, 32'd0);

        // Reset mid-operation with pending set and all IRQs high.
        irq_in = 7'h7F;
        drive(1'b1, 5'd11, 32'd1001);
        step();
        drive(1'b0, 5'd0, 32'd0);
        step();
        chk("pre_rst_intr", {24'd0, interrupts}, 32'hFF);
        reset_n = 1'b0;
        drive(1'b1, 5'd9, 32'd1234);
        step();
        drive(1'b0, 5'd0, 32'd0);
        chk("rst_intr",    {24'd0, interrupts}, 32'h00);
        chk("rst_count",   countreg,   32'd0);
        chk("rst_compare", comparereg, 32'hFFFF_FFFF);
        reset_n = 1'b1;
        step();
        chk("rel1_intr", {24'd0, interrupts}, 32'h00);
        step();
        chk("rel2_intr", {24'd0, interrupts}, 32'h7F);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
